ks_note_sched: RTL and testbench

KS_NOTE_SCHED -- requirements
Module: ks_note_sched

---
 rtl/ks_note_sched.sv | 188 ++++++++++++++++++
 tb/tb_ks_note_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ks_note_sched.sv
// Note scheduler for a Karplus-Strong string/drum voice: round-robin arbitration, pluck, burst and sustain timing.
// Optional build macro KS_NOTE_SCHED_PREEMPT_EN lets any new request cut a note short during sustain.
module ks_note_sched #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned SUST_WIDTH = 16,
  parameter int unsigned PLUCK_HOLD = 8
) (
  input  logic                                          clk_i,
  input  logic                                          rst_ni,
  input  logic [NUM_REQ-1:0]                            req_valid_i,
  output logic [NUM_REQ-1:0]                            req_ready_o,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]                 req_period_i,
  input  logic [NUM_REQ*SUST_WIDTH-1:0]                 req_sustain_i,
  input  logic [NUM_REQ-1:0]                            req_drum_i,
  input  logic                                          hold_i,
  output logic                                          pluck_o,
  output logic [DATA_WIDTH-1:0]                         period_o,
  output logic                                          drum_string_no,
  output logic                                          freeze_o,
  output logic [(NUM_REQ > 1 ? $clog2(NUM_REQ) : 1)-1:0] grant_id_o,
  output logic                                          busy_o,
  output logic                                          note_done_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned PW = $clog2(PLUCK_HOLD + 1);
  localparam int unsigned CW = (PW > DATA_WIDTH + 1) ? PW : DATA_WIDTH + 1;

`ifdef KS_NOTE_SCHED_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_PLUCK   = 3'd2;
  localparam logic [2:0] S_BURST   = 3'd3;
  localparam logic [2:0] S_SUSTAIN = 3'd4;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SUST_WIDTH-1:0] sus_q, sus_d;
  logic [IW-1:0]         cand_q, cand_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [IW-1:0]         grant_d;
  logic [DATA_WIDTH-1:0] period_d;
  logic                  drum_d;
  logic                  pluck_d;
  logic                  busy_d;
  logic                  done_d;
  logic [NUM_REQ-1:0]    ready_d;

  logic [IW-1:0]         winner;
  logic [IW-1:0]         idx;
  logic                  found;

  logic [DATA_WIDTH-1:0] period_arr [NUM_REQ];
  logic [SUST_WIDTH-1:0] sustain_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign period_arr[k]  = req_period_i[k*DATA_WIDTH +: DATA_WIDTH];
    assign sustain_arr[k] = req_sustain_i[k*SUST_WIDTH +: SUST_WIDTH];
  end

  assign freeze_o = hold_i && (state_q == S_SUSTAIN);

  // Round-robin pick: first valid requester after the last granted one.
  always_comb begin
    winner = ptr_q;
    found  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= int'(NUM_REQ); i++) begin
      idx = IW'((int'(ptr_q) + i) % int'(NUM_REQ));
      if (!found && req_valid_i[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sus_d    = sus_q;
    cand_d   = cand_q;
    ptr_d    = ptr_q;
    grant_d  = grant_id_o;
    period_d = period_o;
    drum_d   = drum_string_no;
    done_d   = 1'b0;
    pluck_d  = 1'b0;
    busy_d   = 1'b0;
    ready_d  = '0;

    case (state_q)
      S_IDLE: begin
        if (|req_valid_i) begin
          state_d = S_LOAD;
          cand_d  = winner;
        end
      end
      S_LOAD: begin
        // A requester that withdrew before the handshake simply loses its slot.
        if (req_valid_i[cand_q]) begin
          period_d = (period_arr[cand_q] < DATA_WIDTH'(2)) ? DATA_WIDTH'(2) : period_arr[cand_q];
          drum_d   = req_drum_i[cand_q];
          sus_d    = sustain_arr[cand_q];
          ptr_d    = cand_q;
          grant_d  = cand_q;
          cnt_d    = CW'(PLUCK_HOLD - 1);
          state_d  = S_PLUCK;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PLUCK: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(period_o) + CW'(3);
          state_d = S_BURST;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_BURST: begin
        if (cnt_q == '0) begin
          state_d = S_SUSTAIN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_SUSTAIN: begin
        // A zero sustain count never expires.
        if (PREEMPT && (|req_valid_i)) begin
          state_d = S_LOAD;
          cand_d  = winner;
          done_d  = 1'b1;
        end else if (!freeze_o && (sus_q != '0)) begin
          if (sus_q == SUST_WIDTH'(1)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            sus_d = sus_q - SUST_WIDTH'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pluck_d = (state_d == S_PLUCK);
    busy_d  = (state_d != S_IDLE);
    if (state_d == S_LOAD) begin
      ready_d = NUM_REQ'(1) << cand_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      sus_q          <= '0;
      cand_q         <= '0;
      ptr_q          <= IW'(NUM_REQ - 1);
      grant_id_o     <= '0;
      period_o       <= '0;
      drum_string_no <= 1'b0;
      pluck_o        <= 1'b0;
      busy_o         <= 1'b0;
      note_done_o    <= 1'b0;
      req_ready_o    <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      sus_q          <= sus_d;
      cand_q         <= cand_d;
      ptr_q          <= ptr_d;
      grant_id_o     <= grant_d;
      period_o       <= period_d;
      drum_string_no <= drum_d;
      pluck_o        <= pluck_d;
      busy_o         <= busy_d;
      note_done_o    <= done_d;
      req_ready_o    <= ready_d;
    end
  end

endmodule

// File: tb/tb_ks_note_sched.sv
// Self-checking bench for ks_note_sched: per-note timing, arbitration, clamp, freeze, reset and preemption.
module tb_ks_note_sched;

  localparam int PH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  valid;
  logic [3:0]  ready;
  logic [31:0] period_bus;
  logic [63:0] sustain_bus;
  logic [3:0]  drum_bus;
  logic        hold;
  logic        pluck;
  logic [7:0]  period;
  logic        drum;
  logic        freeze;
  logic [1:0]  grant;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;
  int ptr_m = 3;
  int per_m [4];
  int sus_m [4];
  bit drm_m [4];

  ks_note_sched dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(valid), .req_ready_o(ready),
    .req_period_i(period_bus), .req_sustain_i(sustain_bus), .req_drum_i(drum_bus),
    .hold_i(hold), .pluck_o(pluck), .period_o(period), .drum_string_no(drum),
    .freeze_o(freeze), .grant_id_o(grant), .busy_o(busy), .note_done_o(done)
  );

  always #5 clk = ~clk;

  function automatic int rr_pick(input logic [3:0] m);
    for (int i = 1; i <= 4; i++) begin
      if (m[(ptr_m + i) % 4]) return (ptr_m + i) % 4;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input int p, input int s, input bit d);
    per_m[k] = p; sus_m[k] = s; drm_m[k] = d;
    period_bus[k*8 +: 8]   = 8'(p);
    sustain_bus[k*16 +: 16] = 16'(s);
    drum_bus[k] = d;
  endtask

  // Runs one note from a request mask (entered and left at a negedge) and checks it against the timing model.
  task automatic do_note(input logic [3:0] mask, input bit keep, input int hold_len, input string tag);
    int w, pe, s, exp_busy, hs, hold_left;
    int busy_c, pluck_c, ready_c, bad_ready, freeze_c;
    int gid_seen, per_seen;
    bit drum_seen, finished, started;
    w = rr_pick(mask);
    pe = (per_m[w] < 2) ? 2 : per_m[w];
    s = sus_m[w];
    exp_busy = 1 + PH + pe + 4 + s + hold_len;
    hs = 1 + PH + pe + 4 + 5;
    busy_c = 0; pluck_c = 0; ready_c = 0; bad_ready = 0; freeze_c = 0;
    gid_seen = -1; per_seen = -1; drum_seen = 1'b0; finished = 1'b0; started = 1'b0; hold_left = 0;
    valid = mask;
    for (int c = 0; c < 600 && !finished; c++) begin
      @(negedge clk);
      if (busy) busy_c++;
      if (pluck) begin
        pluck_c++;
        if (!keep) valid = '0;
        per_seen = int'(period); gid_seen = int'(grant); drum_seen = drum;
      end
      if (ready == (4'b0001 << w)) ready_c++;
      else if (ready != 4'b0000) bad_ready++;
      if (freeze) freeze_c++;
      if (done) finished = 1'b1;
      if (hold) begin
        hold_left--;
        if (hold_left == 0) hold = 1'b0;
      end else if (!started && hold_len > 0 && busy_c == hs) begin
        hold = 1'b1; hold_left = hold_len; started = 1'b1;
      end
    end
    hold = 1'b0;
    tests++; if (!finished) begin fails++; $display("FAIL %s note_done: no pulse within budget", tag); end
    tests++; if (ready_c !== 1 || bad_ready !== 0) begin fails++;
      $display("FAIL %s ready: %0d good pulses %0d bad, want 1 pulse on bit %0d", tag, ready_c, bad_ready, w); end
    tests++; if (pluck_c !== PH) begin fails++; $display("FAIL %s pluck_len: got %0d want %0d", tag, pluck_c, PH); end
    tests++; if (busy_c !== exp_busy) begin fails++; $display("FAIL %s busy_len: got %0d want %0d", tag, busy_c, exp_busy); end
    tests++; if (freeze_c !== hold_len) begin fails++; $display("FAIL %s freeze_len: got %0d want %0d", tag, freeze_c, hold_len); end
    tests++; if (per_seen !== pe) begin fails++; $display("FAIL %s period: got %0d want %0d", tag, per_seen, pe); end
    tests++; if (gid_seen !== w) begin fails++; $display("FAIL %s grant_id: got %0d want %0d", tag, gid_seen, w); end
    tests++; if (drum_seen !== drm_m[w]) begin fails++; $display("FAIL %s drum: got %0b want %0b", tag, drum_seen, drm_m[w]); end
    ptr_m = w;
    if (!keep) begin
      valid = '0;
      @(negedge clk);
      tests++; if (done !== 1'b0 || busy !== 1'b0) begin fails++;
        $display("FAIL %s after_note: done=%0b busy=%0b want 0 0", tag, done, busy); end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    tests++;
    if (pluck !== 1'b0 || ready !== 4'b0 || freeze !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        drum !== 1'b0 || period !== 8'd0 || grant !== 2'd0) begin
      fails++;
      $display("FAIL %s reset_values: pluck=%0b ready=%b freeze=%0b busy=%0b done=%0b drum=%0b period=%0d grant=%0d want all 0",
               tag, pluck, ready, freeze, busy, done, drum, period, grant);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = '0; hold = 1'b0;
    period_bus = '0; sustain_bus = '0; drum_bus = '0;
    repeat (2) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("after_release");
    ptr_m = 3;
  endtask

  task automatic test_basic();
    set_req(0, 10, 20, 1'b0);
    do_note(4'b0001, 1'b0, 0, "basic");
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 4; k++) set_req(k, 3 + k, 4 + k, k[0]);
    do_note(4'b1111, 1'b1, 0, "rr0");
    do_note(4'b1111, 1'b1, 0, "rr1");
    do_note(4'b1111, 1'b1, 0, "rr2");
    do_note(4'b1111, 1'b0, 0, "rr3");
  endtask

  task automatic test_period_clamp();
    set_req(1, 0, 6, 1'b1);
    do_note(4'b0010, 1'b0, 0, "period0");
    set_req(3, 1, 3, 1'b0);
    do_note(4'b1000, 1'b0, 0, "period1");
  endtask

  task automatic test_freeze();
    set_req(2, 10, 20, 1'b0);
    do_note(4'b0100, 1'b0, 5, "freeze");
  endtask

  task automatic test_valid_drop();
    logic [7:0] per_before;
    logic [1:0] gid_before;
    int plucks;
    per_before = period; gid_before = grant; plucks = 0;
    valid = 4'b0010;
    @(negedge clk);
    valid = '0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (pluck) plucks++;
    end
    tests++; if (plucks !== 0) begin fails++; $display("FAIL drop pluck: got %0d cycles want 0", plucks); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL drop busy: got %0b want 0", busy); end
    tests++; if (period !== per_before || grant !== gid_before) begin fails++;
      $display("FAIL drop latched: period=%0d grant=%0d want %0d %0d", period, grant, per_before, gid_before); end
  endtask

  task automatic test_random();
    logic [3:0] m;
    int hl;
    for (int n = 0; n < 16; n++) begin
      for (int k = 0; k < 4; k++)
        set_req(k, int'($urandom_range(0, 20)), int'($urandom_range(1, 25)), 1'($urandom_range(0, 1)));
      m = 4'($urandom_range(1, 15));
      hl = (sus_m[rr_pick(m)] >= 8 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 4)) : 0;
      do_note(m, 1'b0, hl, "random");
    end
  endtask

  task automatic test_reset_mid_pluck();
    bit seen;
    seen = 1'b0;
    set_req(2, 7, 9, 1'b1);
    valid = 4'b0100;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (pluck) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL rst_pluck start: pluck not seen within budget"); end
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("mid_pluck");
    valid = '0;
    @(negedge clk);
    check_reset_outputs("mid_pluck_held");
    rst_n = 1'b1;
    ptr_m = 3;
    for (int k = 0; k < 4; k++) set_req(k, 4, 5, 1'b0);
    do_note(4'b1111, 1'b0, 0, "post_reset");
  endtask

  task automatic test_preempt();
    int done_c, ready_c;
    bit seen;
    done_c = 0; ready_c = 0; seen = 1'b0;
    set_req(0, 3, 0, 1'b0);
    set_req(2, 5, 5, 1'b1);
    valid = 4'b0001;
    for (int c = 0; c < 1 + PH + 7 + 10; c++) begin
      @(negedge clk);
      if (pluck) valid = '0;
      if (done) done_c++;
    end
    tests++; if (done_c !== 0 || busy !== 1'b1) begin fails++;
      $display("FAIL sustain0 hold: done=%0d busy=%0b want 0 1", done_c, busy); end
    valid = 4'b0100;
`ifdef KS_NOTE_SCHED_PREEMPT_EN
    @(negedge clk);
    tests++; if (done !== 1'b1 || ready !== 4'b0100) begin fails++;
      $display("FAIL preempt: done=%0b ready=%b want 1 0100", done, ready); end
    for (int c = 0; c < 200 && !seen; c++) begin
      @(negedge clk);
      if (pluck) valid = '0;
      if (done) seen = 1'b1;
    end
    tests++; if (!seen) begin fails++; $display("FAIL preempt note2: no note_done within budget"); end
    tests++; if (grant !== 2'd2) begin fails++; $display("FAIL preempt grant: got %0d want 2", grant); end
    ptr_m = 2;
`else
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (done) done_c++;
      if (ready != 4'b0000) ready_c++;
    end
    tests++; if (done_c !== 0 || ready_c !== 0 || busy !== 1'b1) begin fails++;
      $display("FAIL no_preempt: done=%0d ready=%0d busy=%0b want 0 0 1", done_c, ready_c, busy); end
    rst_n = 1'b0;
    valid = '0;
    @(negedge clk);
    check_reset_outputs("sustain0_reset");
    rst_n = 1'b1;
    ptr_m = 3;
`endif
    valid = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_round_robin();
    test_period_clamp();
    test_freeze();
    test_valid_drop();
    test_random();
    test_reset_mid_pluck();
    test_preempt();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
